fetch_queue: RTL and testbench

Instruction fetch queue that sits directly downstream of the fetch stage and upstream of decode. It buffers up to 2^AW {pc, instruction} pairs in FIFO order and decouples fetch from decode stalls with a valid/ready handshake on both sides. A single-cycle flush discards all buffered entries on a jump or exception redirect.

---
 rtl/fetch_queue.sv | 113 +++++++++++
 tb/tb_fetch_queue.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: FIFO of {pc, inst} pairs between fetch and decode.
// A circular buffer of 2^AW entries with valid/ready on both sides. Flush
// (and reset) discards every buffered entry and any pair offered that cycle.
// Outputs depend only on registers and rst, so there is no combinational path
// from the input handshake to either side.
module fetch_queue #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_inst,
  output logic          in_ready,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_inst,
  input  logic          out_ready,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;
  // Occupancy value meaning "every slot holds an entry".
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  typedef logic [63:0] entry_t;

  // Storage is data only: it is never reset, because occupancy decides
  // which slots are meaningful.
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wp_q, wp_d;
  logic [AW-1:0]   rp_q, rp_d;
  logic [AW:0]     cnt_q, cnt_d;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  entry_t          head;

  // Pointers wrap modulo DEPTH because DEPTH is a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return p + 1'b1;
  endfunction

  // Outputs and handshake qualifiers, built from registers and rst only.
  always_comb begin
    full      = (cnt_q == FULL_CNT);
    empty     = (cnt_q == '0);
    head      = mem_q[rp_q];
    // When full, a same-cycle pop does not open a slot: no pass-through.
    in_ready  = ~rst & ~full;
    out_valid = ~empty;
    out_pc    = empty ? 32'h0 : head[63:32];
    out_inst  = empty ? 32'h0 : head[31:0];
    count     = cnt_q;
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;
  end

  // Next pointer / occupancy: flush wins over push and pop.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = ptr_inc(wp_q);
      if (pop)  rp_d = ptr_inc(rp_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Next storage contents: only the slot under the write pointer changes.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wp_q] = {in_pc, in_inst};
    end
  end

  // Control registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; left untouched by reset and flush.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue (AW = 2): table-driven vectors for fill/drain plus
// hand-written corner sequences, all cross-checked cycle by cycle against a
// queue-based scoreboard.
module tb_fetch_queue;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [31:0]   in_pc, in_inst;
  logic          in_ready, out_valid;
  logic [31:0]   out_pc, out_inst;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  logic [63:0] sb [$];

  fetch_queue #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          r;
    bit          f;
    bit          iv;
    logic [31:0] pc;
    logic [31:0] inst;
    bit          ordy;
    int          exp_cnt;
    bit          exp_rdy;
    bit          exp_vld;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the scoreboard
  // before the edge, advance the model, then step past the edge.
  task automatic cycle(input bit r, input bit f, input bit iv,
                       input logic [31:0] pc, input logic [31:0] inst,
                       input bit ordy);
    bit          m_rdy, m_vld;
    logic [63:0] hd;
    logic [63:0] tmp;
    rst = r; flush = f; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
    #1;
    m_rdy = !r && (sb.size() != DEPTH);
    m_vld = (sb.size() != 0);
    hd    = m_vld ? sb[0] : 64'h0;
    check("sb_in_ready", {31'h0, in_ready}, {31'h0, m_rdy});
    check("sb_out_valid", {31'h0, out_valid}, {31'h0, m_vld});
    check("sb_count", {29'h0, count}, sb.size());
    check("sb_out_pc", out_pc, hd[63:32]);
    check("sb_out_inst", out_inst, hd[31:0]);
    if (r || f) begin
      sb.delete();
    end else begin
      if (m_vld && ordy) tmp = sb.pop_front();
      if (m_rdy && iv)   sb.push_back({pc, inst});
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [9];

  initial begin
    // Fill to full with decode stalled, offer a fifth pair, then drain.
    vecs[0] = '{0,0,1,32'h00,32'hA0,0, 1,1,1,32'h00,32'hA0};
    vecs[1] = '{0,0,1,32'h04,32'hA1,0, 2,1,1,32'h00,32'hA0};
    vecs[2] = '{0,0,1,32'h08,32'hA2,0, 3,1,1,32'h00,32'hA0};
    vecs[3] = '{0,0,1,32'h0C,32'hA3,0, 4,0,1,32'h00,32'hA0};
    vecs[4] = '{0,0,1,32'h10,32'hA4,0, 4,0,1,32'h00,32'hA0};
    vecs[5] = '{0,0,0,32'h00,32'h00,1, 3,1,1,32'h04,32'hA1};
    vecs[6] = '{0,0,0,32'h00,32'h00,1, 2,1,1,32'h08,32'hA2};
    vecs[7] = '{0,0,0,32'h00,32'h00,1, 1,1,1,32'h0C,32'hA3};
    vecs[8] = '{0,0,0,32'h00,32'h00,1, 0,1,0,32'h00,32'h00};

    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_pc = 0; in_inst = 0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    cycle(1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].r, vecs[i].f, vecs[i].iv, vecs[i].pc, vecs[i].inst, vecs[i].ordy);
      in_valid = 0; out_ready = 0;
      #1;
      check($sformatf("vec%0d_count", i), {29'h0, count}, vecs[i].exp_cnt);
      check($sformatf("vec%0d_in_ready", i), {31'h0, in_ready}, {31'h0, vecs[i].exp_rdy});
      check($sformatf("vec%0d_out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].exp_vld});
      check($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_out_inst", i), out_inst, vecs[i].exp_inst);
    end

    // Streaming across two pointer wraps: occupancy holds at 1.
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 1, 32'h100 + 4 * k, 32'hB00 + k, 1);
      check("stream_count", {29'h0, count}, 1);
      check("stream_out_pc", out_pc, 32'h100 + 4 * k);
    end
    cycle(0, 0, 0, 0, 0, 1);
    check("stream_drained", {29'h0, count}, 0);

    // Full with simultaneous pop: push refused, slot reopens next cycle.
    for (int k = 0; k < 4; k++) cycle(0, 0, 1, 32'h400 + 4 * k, 32'hC00 + k, 0);
    cycle(0, 0, 1, 32'h4F0, 32'hCFF, 1);
    in_valid = 0; out_ready = 0;
    #1;
    check("fullpop_count", {29'h0, count}, 3);
    check("fullpop_in_ready", {31'h0, in_ready}, 1);
    check("fullpop_out_pc", out_pc, 32'h404);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 1);

    // Flush with simultaneous push and pop, then a fresh push.
    cycle(0, 0, 1, 32'h1F0, 32'hD0, 0);
    cycle(0, 0, 1, 32'h1F4, 32'hD1, 0);
    cycle(0, 1, 1, 32'h200, 32'hD2, 1);
    in_valid = 0; flush = 0; out_ready = 0;
    #1;
    check("flush_count", {29'h0, count}, 0);
    check("flush_out_valid", {31'h0, out_valid}, 0);
    cycle(0, 0, 1, 32'h300, 32'hD3, 0);
    check("postflush_out_pc", out_pc, 32'h300);
    check("postflush_out_inst", out_inst, 32'hD3);
    cycle(0, 0, 0, 0, 0, 1);

    // Empty push with out_ready high: no bypass.
    cycle(0, 0, 1, 32'h600, 32'hE0, 1);
    check("empty_count", {29'h0, count}, 1);
    check("empty_out_pc", out_pc, 32'h600);
    cycle(0, 0, 0, 0, 0, 1);

    // Reset mid-operation.
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 32'h500 + 4 * k, 32'hF0 + k, 0);
    cycle(1, 0, 1, 32'h5F0, 32'hFF, 1);
    rst = 0; in_valid = 0; out_ready = 0;
    #1;
    check("rst_count", {29'h0, count}, 0);
    check("rst_out_valid", {31'h0, out_valid}, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_inst", out_inst, 0);
    check("rst_in_ready", {31'h0, in_ready}, 1);

    // Random traffic with occasional flush and reset.
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 24) == 0,
            1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
